// File: rtl/rbz_spi_host.sv
// rbz_spi_host: SPI mode-0 host that drives the raybox-zero reg and vec
// peripheral ports. It takes one parallel command (target, bit count,
// left-justified payload) per valid/ready handshake and shifts it out MSB
// first. Every SPI line comes straight from a flop, and the port that is
// not selected is parked at idle.
module rbz_spi_host #(
    parameter int MAX_BITS = 80,
    parameter int LEN_W    = 7,
    parameter int CLK_DIV  = 2,
    parameter int CSB_GAP  = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_target,
    input  logic [LEN_W-1:0]    i_cmd_len,
    input  logic [MAX_BITS-1:0] i_cmd_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_reg_csb,
    output logic                o_reg_sclk,
    output logic                o_reg_mosi,
    output logic                o_vec_csb,
    output logic                o_vec_sclk,
    output logic                o_vec_mosi
);

    localparam int CNT_W = $clog2(MAX_BITS + 1);
    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0] DIV_LOAD = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(CSB_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t              state_reg, state_next;
    logic [TMR_W-1:0]    timer_reg, timer_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [MAX_BITS-1:0] shift_reg, shift_next;
    logic                target_reg, target_next;
    logic                done_reg, done_next;
    logic                ready_reg;
    logic                busy_reg;
    logic [CNT_W-1:0]    len_clamped;
    logic                timer_end;
    logic                frame_next;

    assign timer_end  = (timer_reg == '0);
    assign frame_next = (state_next == ST_SETUP) || (state_next == ST_HIGH) ||
                        (state_next == ST_LOW)   || (state_next == ST_HOLD);

    // Lengths above the payload width are clamped to a full-width frame.
    always_comb begin
        if (int'(i_cmd_len) > MAX_BITS) begin
            len_clamped = CNT_W'(MAX_BITS);
        end else begin
            len_clamped = CNT_W'(i_cmd_len);
        end
    end

    // Next-state logic: every phase is timed by one shared down-counter.
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        target_next  = target_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    target_next  = i_cmd_target;
                    shift_next   = i_cmd_data;
                    bit_cnt_next = len_clamped;
                    if (len_clamped == '0) begin
                        // Empty command: complete at once, stay idle.
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_SETUP;
                        timer_next = DIV_LOAD;
                    end
                end
            end
            ST_SETUP: begin
                if (timer_end) begin
                    state_next = ST_HIGH;
                    timer_next = DIV_LOAD;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            ST_HIGH: begin
                if (timer_end) begin
                    bit_cnt_next = bit_cnt_reg - CNT_W'(1);
                    timer_next   = DIV_LOAD;
                    if (bit_cnt_reg == CNT_W'(1)) begin
                        state_next = ST_HOLD;
                    end else begin
                        // Shift on entry to LOW so mosi moves on the falling edge.
                        state_next = ST_LOW;
                        shift_next = shift_reg << 1;
                    end
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            ST_LOW: begin
                if (timer_end) begin
                    state_next = ST_HIGH;
                    timer_next = DIV_LOAD;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            ST_HOLD: begin
                if (timer_end) begin
                    state_next = ST_GAP;
                    timer_next = GAP_LOAD;
                    done_next  = 1'b1;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (timer_end) begin
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters, and the status flops that are decoded from the next state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            target_reg  <= 1'b0;
            done_reg    <= 1'b0;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            target_reg  <= target_next;
            done_reg    <= done_next;
            ready_reg   <= (state_next == ST_IDLE);
            busy_reg    <= (state_next != ST_IDLE);
        end
    end

    // Line flops for each target. Index 0 is the reg port and index 1 is the vec port.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tgt
            localparam logic TGT = 1'(gi);
            logic csb_q;
            logic sclk_q;
            logic mosi_q;
            logic sel_next;

            assign sel_next = frame_next && (target_next == TGT);

            // This port leaves idle only while a frame addressed to it is in progress.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    csb_q  <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                end else begin
                    csb_q  <= !sel_next;
                    sclk_q <= sel_next && (state_next == ST_HIGH);
                    mosi_q <= sel_next && shift_next[MAX_BITS-1];
                end
            end
        end
    endgenerate

    assign o_reg_csb   = g_tgt[0].csb_q;
    assign o_reg_sclk  = g_tgt[0].sclk_q;
    assign o_reg_mosi  = g_tgt[0].mosi_q;
    assign o_vec_csb   = g_tgt[1].csb_q;
    assign o_vec_sclk  = g_tgt[1].sclk_q;
    assign o_vec_mosi  = g_tgt[1].mosi_q;
    assign o_cmd_ready = ready_reg;
    assign o_busy      = busy_reg;
    assign o_done      = done_reg;

endmodule
